// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the FIFO burst reader
package fifo_pkg;

    localparam int DEF_BITS      = 12;
    localparam int DEF_BURST_LEN = 4;
    localparam int OCC_W         = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } burst_state_t;

endpackage

// File: rtl/fifo_skid_buf2.sv
// rtl/fifo_skid_buf2.sv - two-entry skid buffer absorbing the FIFO read latency
module fifo_skid_buf2
    import fifo_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [BITS-1:0]  push_data,
    input  logic             pop,
    output logic [BITS-1:0]  head,
    output logic [OCC_W-1:0] occ
);

    logic [BITS-1:0]  r_ent0;
    logic [BITS-1:0]  r_ent1;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent0   <= '0;
            r_ent1   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= '0;
        end else begin
            // Overfilling means the credit check upstream is broken.
            assert (!(push && !pop && r_occ == 2'd2));
            if (push) begin
                if (r_wr_ptr) r_ent1 <= push_data;
                else          r_ent0 <= push_data;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign head = r_rd_ptr ? r_ent1 : r_ent0;
    assign occ  = r_occ;

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - FIFO read-side burst streamer; FIFO_BURST_READER_BEATCNT_EN adds burst_cnt
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int CNT_WIDTH = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fifo_ready,
    output logic            fifo_read,
    input  logic [BITS-1:0] fifo_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic            out_last,
    output logic            busy,
    output logic            err_underflow
`ifdef FIFO_BURST_READER_BEATCNT_EN
    ,
    output logic [15:0]     burst_cnt
`endif
);

    burst_state_t         r_state;
    burst_state_t         w_state_nxt;
    logic [CNT_WIDTH-1:0] r_beat;
    logic [CNT_WIDTH-1:0] w_beat_nxt;
    logic                 r_inflight;
    logic                 r_err;
    logic [OCC_W-1:0]     w_occ;
    logic [BITS-1:0]      w_head;
    logic                 w_pop;
    logic                 w_last;
    logic [2:0]           w_level;
    logic                 w_credit;

    fifo_skid_buf2 #(.BITS(BITS)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (fifo_data),
        .pop       (w_pop),
        .head      (w_head),
        .occ       (w_occ)
    );

    assign out_valid = (w_occ != '0);
    assign out_data  = w_head;
    assign w_last    = out_valid && (r_beat == CNT_WIDTH'(BURST_LEN - 1));
    assign out_last  = w_last;
    assign w_pop     = out_valid && out_ready;

    // Buffered plus in-flight words, less the one leaving now, must leave room.
    assign w_level   = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_credit  = w_level < (3'd2 + {2'b00, w_pop});
    assign fifo_read = fifo_ready && !rst && w_credit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat     <= '0;
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat     <= w_beat_nxt;
            r_inflight <= fifo_read;
            r_err      <= r_err | (fifo_read && !fifo_ready);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        if (w_pop) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = '0;
            end else begin
                w_state_nxt = ST_ACTIVE;
                w_beat_nxt  = r_beat + 1'b1;
            end
        end
    end

    assign busy          = (r_state == ST_ACTIVE) || (w_occ != '0) || r_inflight;
    assign err_underflow = r_err;

`ifdef FIFO_BURST_READER_BEATCNT_EN
    logic [15:0] r_burst_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_cnt <= '0;
        end else if (w_pop && w_last && r_burst_cnt != 16'hFFFF) begin
            r_burst_cnt <= r_burst_cnt + 16'd1;
        end
    end

    assign burst_cnt = r_burst_cnt;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_ready;
    logic        fifo_read;
    logic [11:0] fifo_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_last;
    logic        busy;
    logic        err_underflow;
`ifdef FIFO_BURST_READER_BEATCNT_EN
    logic [15:0] burst_cnt;
`endif

    fifo_burst_reader dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_ready    (fifo_ready),
        .fifo_read     (fifo_read),
        .fifo_data     (fifo_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .err_underflow (err_underflow)
`ifdef FIFO_BURST_READER_BEATCNT_EN
        ,
        .burst_cnt     (burst_cnt)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, ready while any word is unread.
    logic [11:0] mem [0:63];
    int          wr_idx = 0;
    int          rd_idx = 0;

    assign fifo_ready = (wr_idx != rd_idx);

    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_data <= mem[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          nb    = 0;
    int          base  = 0;
    logic [11:0] log_data [0:31];
    logic        log_last [0:31];
    int          log_cyc  [0:31];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [11:0] w);
        mem[wr_idx] = w;
        wr_idx++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (out_valid && out_ready && nb < 32) begin
                log_data[nb] = out_data;
                log_last[nb] = out_last;
                log_cyc[nb]  = cyc;
                nb++;
            end
            cyc++;
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(12'(i));

        // Reset with data available: no reads may issue.
        tick();
        check("rst_read_c1", fifo_read, 1'b0);
        tick();
        check("rst_read_c2", fifo_read, 1'b0);
        check("rst_no_fifo_pop", rd_idx, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_read", fifo_read, 1'b1);
        check("post_rst_valid", out_valid, 1'b0);
        check("post_rst_last", out_last, 1'b0);
        check("post_rst_data", out_data, 12'h000);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_err", err_underflow, 1'b0);

        // Streaming at full rate.
        cyc = 0;
        nb  = 0;
        run_cycles(14);
        check("stream_beats", nb, 8);
        check("stream_first_cyc", log_cyc[0], 2);
        check("stream_last_cyc", log_cyc[7], 9);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stream_data%0d", i), log_data[i], 12'(i + 1));
            check($sformatf("stream_last%0d", i), log_last[i], (i == 3 || i == 7));
        end
        check("stream_busy_end", busy, 1'b0);

        // Backpressure from the first beat.
        out_ready = 1'b0;
        base      = rd_idx;
        cyc       = 0;
        nb        = 0;
        for (int i = 1; i <= 8; i++) push_word(12'(i));
        run_cycles(6);
        check("bp_words_read", rd_idx - base, 2);
        check("bp_read_held", fifo_read, 1'b0);
        check("bp_valid", out_valid, 1'b1);
        check("bp_data_held", out_data, 12'h001);
        check("bp_last", out_last, 1'b0);
        check("bp_busy", busy, 1'b1);
        out_ready = 1'b1;
        run_cycles(14);
        check("bp_beats", nb, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bp_data%0d", i), log_data[i], 12'(i + 1));
            check($sformatf("bp_last%0d", i), log_last[i], (i == 3 || i == 7));
        end

        // Burst stalls when the FIFO runs dry, then completes.
        nb = 0;
        push_word(12'h00a);
        push_word(12'h00b);
        push_word(12'h00c);
        run_cycles(8);
        check("stall_beats", nb, 3);
        check("stall_data0", log_data[0], 12'h00a);
        check("stall_data2", log_data[2], 12'h00c);
        check("stall_nolast", {log_last[0], log_last[1], log_last[2]}, 3'b000);
        check("stall_valid", out_valid, 1'b0);
        check("stall_busy", busy, 1'b1);
        run_cycles(10);
        check("stall_long_beats", nb, 3);
        check("stall_long_busy", busy, 1'b1);
        push_word(12'h00d);
        run_cycles(6);
        check("stall_end_beats", nb, 4);
        check("stall_end_data", log_data[3], 12'h00d);
        check("stall_end_last", log_last[3], 1'b1);
        check("stall_end_busy", busy, 1'b0);

        // Reset with beat=2 and a read in flight.
        base = rd_idx;
        cyc  = 0;
        nb   = 0;
        for (int i = 0; i < 8; i++) push_word(12'h010 + 12'(i));
        run_cycles(4);
        check("mid_beats", nb, 2);
        check("mid_reads", rd_idx - base, 4);
        check("mid_valid", out_valid, 1'b1);
        rst       = 1'b1;
        out_ready = 1'b0;
        #1;
        check("mid_rst_read", fifo_read, 1'b0);
        tick();
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_data", out_data, 12'h000);
        check("mid_rst_reads", rd_idx - base, 4);
        rst       = 1'b0;
        out_ready = 1'b1;
        nb        = 0;
        run_cycles(12);
        check("after_rst_beats", nb, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("after_rst_data%0d", i), log_data[i], 12'h014 + 12'(i));
            check($sformatf("after_rst_last%0d", i), log_last[i], (i == 3));
        end
        check("final_err", err_underflow, 1'b0);

`ifdef FIFO_BURST_READER_BEATCNT_EN
        check("bc_after_one", burst_cnt, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("bc_reset", burst_cnt, 16'd0);
        nb = 0;
        for (int i = 0; i < 12; i++) push_word(12'h020 + 12'(i));
        run_cycles(18);
        check("bc_three", burst_cnt, 16'd3);
        force dut.r_burst_cnt = 16'hFFFE;
        #1;
        release dut.r_burst_cnt;
        for (int i = 0; i < 8; i++) push_word(12'h040 + 12'(i));
        run_cycles(14);
        check("bc_saturate", burst_cnt, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the SRAM-backed FIFO (12-bit words, 8-deep).
- Pulls words out with single-cycle read strobes and absorbs the FIFO's 1-cycle read latency in a 2-entry skid buffer.
- Presents the words downstream as a valid/ready stream grouped into fixed-length bursts, with a last-beat marker.
- Sits between the FIFO and any downstream sink, replacing ad-hoc read toggling.

Parameters:
- BITS, 12, data word width; must match the FIFO.
- BURST_LEN, 4, beats per burst (≥2).
- CNT_WIDTH, 3, beat-counter width; must satisfy 2^CNT_WIDTH ≥ BURST_LEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- fifo_ready  in  1  FIFO holds ≥1 unread word.
- fifo_read  out  1  read strobe to FIFO; one word per asserted cycle.
- fifo_data  in  BITS  FIFO read data; valid the cycle after fifo_read.
- out_valid  out  1  out_data/out_last valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  BITS  head word of the skid buffer.
- out_last  out  1  final beat of the current burst.
- busy  out  1  burst open, or words buffered or in flight.
- err_underflow  out  1  sticky; a read was issued while fifo_ready=0 (never by design; checked defensively).

Behaviour:
- Reset (rst=1 at a clk edge) clears every output, the skid buffer, occ, inflight, the beat counter and the FSM.
  - All outputs read 0 the cycle after reset.
  - fifo_read is held 0 while rst=1.
- Occupancy and credit:
  - occ (0..2) = words held in the skid buffer; inflight (0..1) = read issued last cycle.
  - pop = out_valid && out_ready.
  - fifo_read = fifo_ready && !rst && (occ + inflight − pop) < 2. This is combinational from out_ready and gives full throughput: 1 word/cycle sustained when out_ready=1.
- Data capture:
  - When inflight=1, fifo_data is written into the skid buffer at the tail.
  - Simultaneous push and pop is legal and leaves occ unchanged.
  - occ never exceeds 2; any push at occ=2 with no pop is a design error, flagged by an assertion.
- Output:
  - out_valid = (occ > 0). out_data is the buffer head.
  - out_data and out_last stay stable while out_valid && !out_ready.
- Burst FSM, states IDLE and ACTIVE, with beat counter beat (0..BURST_LEN−1):
  - IDLE → ACTIVE on the first pop. beat becomes 1, or the FSM stays in IDLE if BURST_LEN reached (not possible given BURST_LEN≥2).
  - In ACTIVE, each pop increments beat.
  - out_last = out_valid && (beat == BURST_LEN−1).
  - A pop with out_last set returns the FSM to IDLE with beat=0.
- A burst may stall mid-way when the FIFO empties. The FSM stays in ACTIVE indefinitely, with no timeout and no partial bursts.
- busy = (state==ACTIVE) || occ>0 || inflight.
- err_underflow sets when fifo_read && !fifo_ready and clears only on rst.
- Reset mid-burst: the burst is abandoned, buffered words are dropped, and a read in flight is discarded (inflight cleared, so its data is not captured).

Optional Feature:
- Macro: FIFO_BURST_READER_BEATCNT_EN.
- Defined:
  - Adds output port burst_cnt [15:0], a saturating count of completed bursts (pops with out_last).
  - burst_cnt saturates at 16'hFFFF and is cleared on rst.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg:
  - FSM state typedef (IDLE, ACTIVE).
  - Default BITS=12 and BURST_LEN=4 constants.
  - Occupancy width constant.
- One natural sub-module, fifo_skid_buf2: 2-entry BITS-wide buffer with push/pop/occ, instantiated once. The FSM and credit logic stay in the top level.

Test Plan:
- Reset behaviour: assert rst for 2 cycles with fifo_ready=1 → fifo_read=0 throughout; all outputs 0 the cycle after release; first fifo_read on the first cycle after release.
- Streaming: FIFO model preloaded with 12'h001..12'h008, out_ready=1 → 8 beats on consecutive cycles, starting 2 cycles after the first read; out_last on 12'h004 and 12'h008; busy drops after the 12'h008 pop.
- Backpressure: same data, out_ready=0 for cycles 3–6 → exactly 2 words buffered, fifo_read=0 while stalled, out_data held at 12'h001; the sequence resumes intact with no loss or duplication.
- Mid-burst stall: FIFO holds 12'h00a..12'h00c, then refilled with 12'h00d after 10 cycles → beats 12'h00a..c without out_last; FSM stays ACTIVE and busy=1; 12'h00d carries out_last.
- Reset mid-burst: assert rst the cycle after a fifo_read, on beat 2 → returned word is not captured, out_valid=0, beat=0; the next burst's first pop has out_last=0 and the fourth pop has out_last=1.
- With FIFO_BURST_READER_BEATCNT_EN defined: 12 words streamed → burst_cnt=3; force the counter to 16'hFFFE, complete 2 more bursts → burst_cnt=16'hFFFF.
